// File: rtl/srl_fifo_drain_arb.sv
`timescale 1ns/1ps
// srl_fifo_drain_arb
// Round-robin drain arbiter: moves beats from nreq upstream SRL FIFOs into one
// shared downstream SRL FIFO.
//
// Handshake: a beat moves in cycle t exactly when the FSM is in BURST, the
// granted upstream FIFO is not empty (EMPTY_N[sel]) and the downstream FIFO is
// not full (OUT_FULL_N). In that cycle DEQ[sel] and OUT_ENQ are both high, and
// OUT_D/OUT_EOP carry the head beat of the granted FIFO. Both strobes are
// combinational from registered state and the current flags, so FIFO flags
// are honored in the same cycle. OUT_D/OUT_EOP are meaningful only while
// OUT_ENQ is high.
//
// A grant is held for a whole packet (until a beat with EOP moves) or until
// max_burst beats have moved (max_burst=0 means no limit). Each grant is
// followed by exactly one IDLE cycle, in which the next requester is chosen
// by scanning upward from the one after the last granted index.
//
// DBG_STATE / DBG_LAST expose the FSM state and the round-robin pointer for
// checkers.
module srl_fifo_drain_arb #(
  parameter int width     = 32,
  parameter int nreq      = 4,
  parameter int max_burst = 8
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     CLR,
  input  logic [nreq-1:0]          EN,
  input  logic [nreq-1:0]          EMPTY_N,
  input  logic [nreq-1:0]          EOP,
  input  logic [nreq*width-1:0]    D_IN,
  output logic [nreq-1:0]          DEQ,
  input  logic                     OUT_FULL_N,
  output logic                     OUT_ENQ,
  output logic [width-1:0]         OUT_D,
  output logic                     OUT_EOP,
  output logic [nreq-1:0]          GRANT,
  output logic                     BUSY,
  output logic                     DBG_STATE,
  output logic [$clog2(nreq)-1:0]  DBG_LAST
);

  localparam int sel_w  = $clog2(nreq);
  localparam int beat_w = (max_burst == 0) ? 1 : $clog2(max_burst + 1);

  // Beat count at which a limited burst ends (on a transfer).
  localparam logic [beat_w-1:0] beats_last =
    (max_burst == 0) ? '0 : beat_w'(max_burst - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [sel_w-1:0]   sel_q, sel_d;
  logic [sel_w-1:0]   last_q, last_d;
  logic [beat_w-1:0]  beats_q, beats_d;

  logic               clr_any;
  logic               in_burst;
  logic               xfer;
  logic               limit_hit;
  logic               burst_end;
  logic [nreq-1:0]    elig;
  logic               pick_found;
  logic [sel_w-1:0]   pick_idx;
  int                 scan_idx;
  logic [sel_w-1:0]   scan_sel;

  // Reset and clear act identically; both also squash any transfer this cycle.
  assign clr_any  = !RST_N || CLR;
  assign in_burst = (state_q == S_BURST) && !clr_any;
  assign xfer     = in_burst && EMPTY_N[sel_q] && OUT_FULL_N;

  // The limit term is tied off when bursts are unlimited.
  assign limit_hit = (max_burst != 0) && (beats_q == beats_last);
  assign burst_end = xfer && (EOP[sel_q] || limit_hit);

  // Requesters that may win the next arbitration (EN only matters here).
  assign elig = EN & EMPTY_N;

  // Round-robin scan: start just after the last granted index, wrap around,
  // take the first eligible requester.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_idx   = 0;
    scan_sel   = '0;
    for (int i = 1; i <= nreq; i++) begin
      scan_idx = (int'(last_q) + i) % nreq;
      scan_sel = sel_w'(scan_idx);
      if (!pick_found && elig[scan_sel]) begin
        pick_found = 1'b1;
        pick_idx   = scan_sel;
      end
    end
  end

  // Next-state logic for the IDLE/BURST FSM and its bookkeeping registers.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    beats_d = beats_q;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          state_d = S_BURST;
          sel_d   = pick_idx;
          beats_d = '0;
        end
      end
      S_BURST: begin
        // An empty upstream FIFO or a full downstream FIFO simply stalls the
        // burst; the grant is kept with no timeout.
        if (xfer) begin
          beats_d = beats_q + 1'b1;
          if (burst_end) begin
            state_d = S_IDLE;
            last_d  = sel_q;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset and synchronous clear.
  // last resets to nreq-1 so that requester 0 is scanned first.
  always_ff @(posedge CLK) begin
    if (clr_any) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      last_q  <= sel_w'(nreq - 1);
      beats_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      beats_q <= beats_d;
    end
  end

  // Strobes, grant vector and the data mux for the granted requester.
  always_comb begin
    DEQ   = '0;
    GRANT = '0;
    if (xfer) begin
      DEQ[sel_q] = 1'b1;
    end
    if (in_burst) begin
      GRANT[sel_q] = 1'b1;
    end
    OUT_ENQ = xfer;
    BUSY    = in_burst;
    OUT_D   = D_IN[int'(sel_q)*width +: width];
    OUT_EOP = EOP[sel_q];
  end

  assign DBG_STATE = (state_q == S_BURST);
  assign DBG_LAST  = last_q;

  // Structural invariants of the strobes and grant.
  a_grant_onehot0 : assert property (@(posedge CLK) disable iff (!RST_N)
    $onehot0(GRANT));
  a_deq_onehot0 : assert property (@(posedge CLK) disable iff (!RST_N)
    $onehot0(DEQ));
  a_deq_within_grant : assert property (@(posedge CLK) disable iff (!RST_N)
    (DEQ & ~GRANT) == '0);
  a_enq_matches_deq : assert property (@(posedge CLK) disable iff (!RST_N)
    OUT_ENQ == (|DEQ));

endmodule

// File: tb/tb_srl_fifo_drain_arb.sv
`timescale 1ns/1ps
// Directed bench for srl_fifo_drain_arb. Three instances cover max_burst = 8,
// 4 and 0; only the selected one is active, the others are held in CLR.
// Upstream FIFOs are modelled as queues popped on observed DEQ; downstream
// beats are compared in order against a hand-built expected queue.
module tb_srl_fifo_drain_arb;

  localparam int W = 32;
  localparam int N = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n = 1'b0;
  logic           clr   = 1'b0;
  logic [N-1:0]   en    = '1;
  logic [N-1:0]   empty_n = '0;
  logic [N-1:0]   eop   = '0;
  logic [N*W-1:0] d_in  = '0;
  logic           full_n = 1'b1;
  logic [N-1:0]   hold_empty = '0;
  int             which = 0;

  logic [2:0]     clr_v;
  logic [N-1:0]   deq_a [3];
  logic           enq_a [3];
  logic [W-1:0]   od_a [3];
  logic           oeop_a [3];
  logic [N-1:0]   grant_a [3];
  logic           busy_a [3];
  logic           dst_a [3];
  logic [1:0]     dlast_a [3];

  logic [N-1:0]   deq, grant;
  logic           out_enq, out_eop, busy, dbg_state;
  logic [W-1:0]   out_d;
  logic [1:0]     dbg_last;

  assign clr_v[0] = (which == 0) ? clr : 1'b1;
  assign clr_v[1] = (which == 1) ? clr : 1'b1;
  assign clr_v[2] = (which == 2) ? clr : 1'b1;

  srl_fifo_drain_arb #(.width(W), .nreq(N), .max_burst(8)) u_dut_b8 (
    .CLK(clk), .RST_N(rst_n), .CLR(clr_v[0]), .EN(en), .EMPTY_N(empty_n),
    .EOP(eop), .D_IN(d_in), .DEQ(deq_a[0]), .OUT_FULL_N(full_n),
    .OUT_ENQ(enq_a[0]), .OUT_D(od_a[0]), .OUT_EOP(oeop_a[0]),
    .GRANT(grant_a[0]), .BUSY(busy_a[0]), .DBG_STATE(dst_a[0]),
    .DBG_LAST(dlast_a[0]));

  srl_fifo_drain_arb #(.width(W), .nreq(N), .max_burst(4)) u_dut_b4 (
    .CLK(clk), .RST_N(rst_n), .CLR(clr_v[1]), .EN(en), .EMPTY_N(empty_n),
    .EOP(eop), .D_IN(d_in), .DEQ(deq_a[1]), .OUT_FULL_N(full_n),
    .OUT_ENQ(enq_a[1]), .OUT_D(od_a[1]), .OUT_EOP(oeop_a[1]),
    .GRANT(grant_a[1]), .BUSY(busy_a[1]), .DBG_STATE(dst_a[1]),
    .DBG_LAST(dlast_a[1]));

  srl_fifo_drain_arb #(.width(W), .nreq(N), .max_burst(0)) u_dut_b0 (
    .CLK(clk), .RST_N(rst_n), .CLR(clr_v[2]), .EN(en), .EMPTY_N(empty_n),
    .EOP(eop), .D_IN(d_in), .DEQ(deq_a[2]), .OUT_FULL_N(full_n),
    .OUT_ENQ(enq_a[2]), .OUT_D(od_a[2]), .OUT_EOP(oeop_a[2]),
    .GRANT(grant_a[2]), .BUSY(busy_a[2]), .DBG_STATE(dst_a[2]),
    .DBG_LAST(dlast_a[2]));

  always_comb begin
    deq = deq_a[0]; out_enq = enq_a[0]; out_d = od_a[0]; out_eop = oeop_a[0];
    grant = grant_a[0]; busy = busy_a[0]; dbg_state = dst_a[0];
    dbg_last = dlast_a[0];
    case (which)
      1: begin
        deq = deq_a[1]; out_enq = enq_a[1]; out_d = od_a[1]; out_eop = oeop_a[1];
        grant = grant_a[1]; busy = busy_a[1]; dbg_state = dst_a[1];
        dbg_last = dlast_a[1];
      end
      2: begin
        deq = deq_a[2]; out_enq = enq_a[2]; out_d = od_a[2]; out_eop = oeop_a[2];
        grant = grant_a[2]; busy = busy_a[2]; dbg_state = dst_a[2];
        dbg_last = dlast_a[2];
      end
      default: ;
    endcase
  end

  // ---------------- scoreboard ----------------
  logic [W:0] up_q [N][$];
  logic [W:0] exp_q [$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got,
                          input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] mk_d(input int k, input int i);
    return 32'(32'h1000 * (k + 1) + i);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic load_pkt(input int k, input int first, input int n,
                          input bit eop_last);
    logic e;
    for (int i = 0; i < n; i++) begin
      e = eop_last && (i == n - 1);
      up_q[k].push_back({e, mk_d(k, first + i)});
    end
  endtask

  task automatic exp_pkt(input int k, input int first, input int n,
                         input int eop_at);
    logic e;
    for (int i = 0; i < n; i++) begin
      e = ((first + i) == eop_at);
      exp_q.push_back({e, mk_d(k, first + i)});
    end
  endtask

  task automatic refresh_inputs();
    for (int k = 0; k < N; k++) begin
      empty_n[k] = (up_q[k].size() != 0) && !hold_empty[k];
      if (up_q[k].size() != 0) begin
        eop[k]          = up_q[k][0][W];
        d_in[k*W +: W]  = up_q[k][0][W-1:0];
      end else begin
        eop[k]          = 1'b0;
        d_in[k*W +: W]  = '0;
      end
    end
  endtask

  // One clock cycle: outputs sampled on the falling edge, upstream queues
  // popped just after the rising edge.
  task automatic tick(input bit do_chk, input string tag,
                      input logic [N-1:0] eg, input logic [N-1:0] ed);
    logic [N-1:0] deq_s;
    logic [W:0]   e;
    refresh_inputs();
    @(negedge clk);
    deq_s = deq;
    if (do_chk) begin
      check_eq({tag, "_grant"}, grant, eg);
      check_eq({tag, "_deq"}, deq, ed);
      check_eq({tag, "_enq"}, out_enq, |ed);
      check_eq({tag, "_busy"}, busy, |eg);
    end
    if (out_enq) begin
      if (exp_q.size() == 0) begin
        check_eq({tag, "_sb_extra"}, exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        check_eq({tag, "_sb_beat"}, {out_eop, out_d}, e);
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      if (deq_s[k] && up_q[k].size() != 0) void'(up_q[k].pop_front());
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; clr = 1'b0; en = '1; full_n = 1'b1; hold_empty = '0;
    for (int k = 0; k < N; k++) up_q[k].delete();
    exp_q.delete();
    tick(1, "rst", 4'b0000, 4'b0000);
    tick(1, "rst", 4'b0000, 4'b0000);
    check_eq("rst_state", dbg_state, 0);
    check_eq("rst_last", dbg_last, 3);
    rst_n = 1'b1;
  endtask

  // ---------------- directed tests ----------------
  initial begin
    // Single requester, 3-beat packet on FIFO1.
    which = 0;
    do_reset();
    load_pkt(1, 0, 3, 1);
    exp_pkt(1, 0, 3, 2);
    tick(1, "single_idle", 4'b0000, 4'b0000);
    for (int b = 0; b < 3; b++) tick(1, "single", 4'b0010, 4'b0010);
    tick(1, "single_gap", 4'b0000, 4'b0000);
    check_eq("single_last", dbg_last, 1);
    tick(1, "single_quiet", 4'b0000, 4'b0000);
    check_eq("single_sb_left", exp_q.size(), 0);

    // Backpressure: downstream full for 5 cycles mid-burst.
    which = 0;
    do_reset();
    load_pkt(0, 0, 6, 1);
    exp_pkt(0, 0, 6, 5);
    tick(1, "bp_idle", 4'b0000, 4'b0000);
    for (int b = 0; b < 2; b++) tick(1, "bp_pre", 4'b0001, 4'b0001);
    full_n = 1'b0;
    for (int b = 0; b < 5; b++) tick(1, "bp_stall", 4'b0001, 4'b0000);
    full_n = 1'b1;
    for (int b = 0; b < 4; b++) tick(1, "bp_post", 4'b0001, 4'b0001);
    tick(1, "bp_gap", 4'b0000, 4'b0000);
    check_eq("bp_sb_left", exp_q.size(), 0);

    // Mask: requester 2 disabled; EN[0] dropped mid-burst.
    which = 0;
    do_reset();
    en = 4'b1011;
    for (int k = 0; k < N; k++) load_pkt(k, 0, 2, 1);
    exp_pkt(0, 0, 2, 1);
    exp_pkt(1, 0, 2, 1);
    exp_pkt(3, 0, 2, 1);
    tick(1, "mask_idle", 4'b0000, 4'b0000);
    for (int b = 0; b < 2; b++) tick(1, "mask_r0", 4'b0001, 4'b0001);
    tick(1, "mask_gap", 4'b0000, 4'b0000);
    for (int b = 0; b < 2; b++) tick(1, "mask_r1", 4'b0010, 4'b0010);
    tick(1, "mask_gap", 4'b0000, 4'b0000);
    for (int b = 0; b < 2; b++) tick(1, "mask_r3", 4'b1000, 4'b1000);
    tick(1, "mask_gap", 4'b0000, 4'b0000);
    tick(1, "mask_skip2", 4'b0000, 4'b0000);
    check_eq("mask_r2_untouched", up_q[2].size(), 2);
    load_pkt(0, 8, 3, 1);
    exp_pkt(0, 8, 3, 10);
    tick(1, "mask_idle2", 4'b0000, 4'b0000);
    tick(1, "mask_en", 4'b0001, 4'b0001);
    en = 4'b1010;
    for (int b = 0; b < 2; b++) tick(1, "mask_en_off", 4'b0001, 4'b0001);
    tick(1, "mask_end", 4'b0000, 4'b0000);
    tick(1, "mask_end2", 4'b0000, 4'b0000);
    check_eq("mask_sb_left", exp_q.size(), 0);

    // CLR on beat 2 of a 5-beat burst on FIFO3.
    which = 0;
    do_reset();
    load_pkt(3, 0, 5, 1);
    exp_pkt(3, 0, 1, 4);
    exp_pkt(1, 0, 2, 1);
    exp_pkt(3, 1, 4, 4);
    tick(1, "clr_idle", 4'b0000, 4'b0000);
    tick(1, "clr_b1", 4'b1000, 4'b1000);
    clr = 1'b1;
    tick(1, "clr_cyc", 4'b0000, 4'b0000);
    clr = 1'b0;
    check_eq("clr_state", dbg_state, 0);
    check_eq("clr_last", dbg_last, 3);
    load_pkt(1, 0, 2, 1);
    tick(1, "clr_after", 4'b0000, 4'b0000);
    for (int b = 0; b < 2; b++) tick(1, "clr_r1", 4'b0010, 4'b0010);
    tick(1, "clr_gap", 4'b0000, 4'b0000);
    for (int b = 0; b < 4; b++) tick(1, "clr_r3", 4'b1000, 4'b1000);
    tick(1, "clr_end", 4'b0000, 4'b0000);
    check_eq("clr_sb_left", exp_q.size(), 0);

    // Fairness with max_burst=4: grants rotate 0,1,2,3,0.
    which = 1;
    do_reset();
    for (int k = 0; k < N; k++) load_pkt(k, 0, 10, 0);
    for (int g = 0; g < 5; g++) exp_pkt(g % 4, (g / 4) * 4, 4, -1);
    for (int g = 0; g < 5; g++) begin
      tick(1, "fair_gap", 4'b0000, 4'b0000);
      for (int b = 0; b < 4; b++)
        tick(1, "fair", 4'(1 << (g % 4)), 4'(1 << (g % 4)));
    end
    tick(1, "fair_end", 4'b0000, 4'b0000);
    check_eq("fair_last", dbg_last, 0);
    check_eq("fair_sb_left", exp_q.size(), 0);

    // Underrun with max_burst=0: FIFO2 empties after beat 2.
    which = 2;
    do_reset();
    load_pkt(2, 0, 6, 1);
    exp_pkt(2, 0, 6, 5);
    exp_pkt(0, 0, 2, 1);
    tick(1, "ur_idle", 4'b0000, 4'b0000);
    for (int b = 0; b < 2; b++) tick(1, "ur_pre", 4'b0100, 4'b0100);
    hold_empty[2] = 1'b1;
    load_pkt(0, 0, 2, 1);
    for (int b = 0; b < 4; b++) tick(1, "ur_wait", 4'b0100, 4'b0000);
    hold_empty[2] = 1'b0;
    for (int b = 0; b < 4; b++) tick(1, "ur_post", 4'b0100, 4'b0100);
    tick(1, "ur_gap", 4'b0000, 4'b0000);
    check_eq("ur_last", dbg_last, 2);
    for (int b = 0; b < 2; b++) tick(1, "ur_r0", 4'b0001, 4'b0001);
    tick(1, "ur_end", 4'b0000, 4'b0000);
    check_eq("ur_sb_left", exp_q.size(), 0);

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/srl_fifo_drain_arb.md
# srl_fifo_drain_arb

Round-robin drain arbiter that shares one downstream SRL FIFO among `nreq` upstream SRL FIFOs. It holds a grant for a whole packet, or for up to `max_burst` beats. For each transfer it asserts DEQ on the granted upstream FIFO and ENQ on the downstream FIFO in the same cycle. It sits between per-channel ingress FIFOs and a shared egress FIFO on a worker's data path.

## Interface
- `width`, 32, data beat width (EOP carried separately).
- `nreq`, 4, number of upstream FIFOs (2..16).
- `max_burst`, 8, maximum beats per grant; 0 = unlimited, grant ends only on EOP.
- CLK  input  1  clock; all state changes on rising edge.
- RST_N  input  1  reset, synchronous, active-low.
- CLR  input  1  synchronous clear, same effect as reset.
- EN  input  nreq  per-requester enable mask, sampled only in IDLE.
- EMPTY_N  input  nreq  upstream FIFO not-empty flags.
- EOP  input  nreq  end-of-packet flag of each upstream FIFO's head beat.
- D_IN  input  nreq*width  upstream head data, requester k at bits [k*width +: width].
- DEQ  output  nreq  upstream dequeue strobes, at most one bit set.
- OUT_FULL_N  input  1  downstream FIFO not-full.
- OUT_ENQ  output  1  downstream enqueue strobe.
- OUT_D  output  width  downstream data.
- OUT_EOP  output  1  downstream EOP flag.
- GRANT  output  nreq  one-hot current grant; all zero in IDLE.
- BUSY  output  1  high in BURST state.

## Operation
- State machine, two states: IDLE and BURST. Registers:
  - `state`
  - `sel` (clog2(nreq) bits)
  - `last` (last granted index)
  - `beats` (clog2(max_burst+1) bits, minimum 1 bit)
- Reset/CLR:
  - state=IDLE, sel=0, last=nreq-1 so requester 0 has first priority, beats=0.
  - Outputs during reset/CLR: DEQ=0, OUT_ENQ=0, GRANT=0, BUSY=0.
- IDLE:
  - Eligible requesters are those with EN[k] && EMPTY_N[k].
  - Scan from (last+1) mod nreq upward with wrap; the first eligible k is granted.
  - On a grant, next cycle: state=BURST, sel=k, beats=0.
  - If no requester is eligible, stay in IDLE.
  - No transfer occurs in IDLE.
- BURST:
  - xfer = EMPTY_N[sel] && OUT_FULL_N && RST_N && !CLR.
  - DEQ[sel] = OUT_ENQ = xfer.
  - OUT_D = D_IN[sel], OUT_EOP = EOP[sel]. These are combinational from the mux and valid only when OUT_ENQ=1.
  - On xfer, beats increments.
  - The burst ends on xfer when EOP[sel]=1, or when max_burst!=0 and beats==max_burst-1. On the end: state goes to IDLE next cycle and last=sel.
  - If the granted FIFO goes empty mid-packet, the grant is held and the block waits, with no timeout.
  - Dropping EN[sel] mid-burst does not end the burst.
  - Downstream full stalls the burst; the grant is held.
- With max_burst!=0, a packet longer than max_burst is split across grants. Beats stay in order per requester; beats of different requesters may interleave downstream. Users needing packet integrity set max_burst=0.

## Timing
- Arbitration latency: 1 cycle. Request seen in IDLE at cycle n, first possible transfer at n+1.
- Throughput in BURST: 1 beat/cycle while EMPTY_N[sel] and OUT_FULL_N are high.
- Inter-burst gap: exactly 1 IDLE cycle. This holds even when the same requester is re-granted.
- DEQ/OUT_ENQ are combinational from registered state and the current flags. There are no added register stages, so upstream and downstream FIFO flags are honored in the same cycle.
- Beat counter: saturates by construction, because the burst ends at max_burst-1 on xfer. No wrap-around is reachable.
- Reset or CLR asserted mid-burst: no DEQ/ENQ in that cycle; next cycle is IDLE with priority restarting at 0.
- Simultaneous EOP and beats==max_burst-1: a single end-of-burst, last=sel.

## Test plan
- Single requester, nreq=4, max_burst=8: FIFO1 holds a 3-beat packet (EOP on beat 3) -> GRANT=0010 from cycle 1; 3 consecutive DEQ[1]/OUT_ENQ; 1 IDLE cycle; last=1.
- Fairness: all four FIFOs hold long packets, max_burst=4 -> grants rotate 0,1,2,3,0, each exactly 4 beats with a 1-cycle gap; no requester is skipped.
- Backpressure: OUT_FULL_N low for 5 cycles mid-burst -> DEQ=0 and OUT_ENQ=0 for those 5 cycles, grant held, no beat lost or duplicated, data order preserved.
- Upstream underrun with max_burst=0: EMPTY_N[2] drops after beat 2 of a 6-beat packet -> GRANT stays 0100 and no DEQ; requester 0 is not granted despite pending data; the burst resumes when EMPTY_N[2] rises.
- Mask: EN=1011 with all FIFOs non-empty -> requester 2 is never granted; EN[0] cleared during a burst of requester 0 -> the burst completes.
- CLR on beat 2 of a 5-beat burst -> no DEQ that cycle, BUSY=0 next cycle, next grant goes to the lowest-index eligible requester.
